// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with registered pin drive,
// leading-zero blanking on the middle digits and a per-scan FRAME strobe.
module ssd_scan_ctrl #(
   parameter int CLK_DIV  = 50000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] BCDIN,
   input  logic        LOAD,
   input  logic [3:0]  DP,
   output logic [3:0]  AN,
   output logic [6:0]  SEG,
   output logic        DPOUT,
   output logic        FRAME
);

   localparam logic [15:0] TC_VAL = 16'(CLK_DIV - 1);

   logic [15:0] presc_q, presc_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] code_q, code_d;
   logic [3:0]  dp_q, dp_d;
   logic [3:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dpout_q, dpout_d;
   logic        frame_q, frame_d;

   logic        tc;
   logic [3:0]  digit;
   logic        blank2, blank1, lz_blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] c);
      logic [6:0] s;
      case (c)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hF:    s = 7'b0111111;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_comb begin
      tc      = (presc_q == TC_VAL);
      presc_d = tc ? 16'd0 : presc_q + 16'd1;
      idx_d   = tc ? idx_q + 2'd1 : idx_q;
      code_d  = LOAD ? BCDIN : code_q;
      dp_d    = LOAD ? DP : dp_q;
   end

   // Outputs are derived from the pre-edge index and shadows, so a LOAD or
   // index change shows up on the pins one cycle later.
   always_comb begin
      digit    = code_q[{idx_q, 2'b00} +: 4];
      blank2   = BLANK_LZ && (code_q[11:8] == 4'h0);
      blank1   = blank2 && (code_q[7:4] == 4'h0);
      lz_blank = ((idx_q == 2'd2) && blank2) || ((idx_q == 2'd1) && blank1);
      seg_d    = lz_blank ? 7'b1111111 : seg_decode(digit);
      dpout_d  = ~dp_q[idx_q];
      frame_d  = tc && (idx_q == 2'd3);
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_an
      assign an_d[gi] = (idx_q != 2'(gi));
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         presc_q <= 16'd0;
         idx_q   <= 2'd0;
         code_q  <= 16'hAAAA;
         dp_q    <= 4'd0;
         an_q    <= 4'b1111;
         seg_q   <= 7'b1111111;
         dpout_q <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         code_q  <= code_d;
         dp_q    <= dp_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dpout_q <= dpout_d;
         frame_q <= frame_d;
      end
   end

   assign AN    = an_q;
   assign SEG   = seg_q;
   assign DPOUT = dpout_q;
   assign FRAME = frame_q;

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, meaning clocks per digit slot (2 kHz digit rate at 100 MHz); legal range 2..65535.
REQ-002 SHALL have parameter BLANK_LZ, default 1, meaning 1 = leading-zero blanking enabled on digits 2 and 1.
REQ-003 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous active-low reset.
REQ-005 SHALL have port BCDIN  input  16  four display codes, [15:12] = digit 3 (leftmost, sign) down to [3:0] = digit 0.
REQ-006 SHALL have port LOAD  input  1  single-cycle strobe; latch BCDIN into shadow register.
REQ-007 SHALL have port DP  input  4  decimal-point enable per digit, bit n = digit n, sampled with LOAD.
REQ-008 SHALL have port AN  output  4  anode enables, active-low, bit n = digit n.
REQ-009 SHALL have port SEG  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port DPOUT  output  1  decimal-point cathode, active-low.
REQ-011 SHALL have port FRAME  output  1  one-cycle pulse each completed 4-digit scan; usable as upstream conversion start.

Function
REQ-012 SHALL hold a 16-bit code shadow and 4-bit DP shadow, both written only on the edge where LOAD = 1.
REQ-013 SHALL run prescaler 0..CLK_DIV-1, wrapping to 0; terminal count (TC) = prescaler at CLK_DIV-1.
REQ-014 SHALL advance digit index 0->1->2->3->0 on each TC edge; index holds otherwise.
REQ-015 SHALL register AN, SEG, DPOUT every cycle from current index and shadows (one-cycle latency from index or shadow change to pins).
REQ-016 SHALL drive AN one-hot-low at bit = index; never more than one AN bit low.
REQ-017 SHALL decode codes 0-9 to: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 SHALL decode code 0xF as minus (SEG=0111111) and codes 0xA-0xE as blank (SEG=1111111).
REQ-019 SHALL, when BLANK_LZ=1, blank digit 2 if its code is 0, and blank digit 1 if its code is 0 and digit 2 was blanked; digit 0 and digit 3 are never zero-blanked.
REQ-020 SHALL drive DPOUT = ~DP shadow[index]; DP is not suppressed on blanked digits.
REQ-021 SHALL pulse FRAME high for exactly one cycle, the cycle after the TC edge that moves index 3->0.
REQ-022 SHALL, on LOAD coinciding with TC, apply the new shadow and new index together; the output registers reflect both on the following edge.
REQ-023 SHALL accept LOAD on consecutive cycles; last value wins; no effect on prescaler or index.

Reset
REQ-024 SHALL, while RST = 0, asynchronously force prescaler=0, index=0, code shadow=16'hAAAA, DP shadow=0, AN=1111, SEG=1111111, DPOUT=1, FRAME=0.
REQ-025 SHALL, on first edge after RST release, output AN=1110 with digit 0 decoded from shadow (blank), first TC occurring CLK_DIV cycles after release.
REQ-026 SHALL abort any scan on mid-operation reset; no FRAME pulse is emitted for the interrupted scan.

Verification (CLK_DIV=4 unless stated)
REQ-027 Reset then LOAD BCDIN=16'hF123, DP=0000 -> scan shows AN 1110/1101/1011/0111 with SEG 0110000/0100100/1111001/0111111, each slot 4 cycles.
REQ-028 BLANK_LZ=1, LOAD 16'hA005 -> digits 3,2,1 SEG=1111111, digit 0 SEG=0010010; LOAD 16'hA105 -> digit 1 SEG=1000000 shown.
REQ-029 Free run 64 cycles after reset -> FRAME pulses exactly 4 times, 16 cycles apart, each one cycle wide, first at cycle 17 after release.
REQ-030 LOAD 16'hA888 asserted on a TC edge while index=0 -> next edge AN=1101 and SEG=0000000.
REQ-031 Assert RST low mid-slot on index 2 -> AN=1111, SEG=1111111, FRAME=0 immediately without clock; after release scan restarts at digit 0 with blank shadow.
REQ-032 LOAD DP=0100 -> DPOUT=0 only while AN=1011, DPOUT=1 in all other slots.
